// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequences one RV32I load or store at a time onto a word-addressed
//            memory port. Stores are lane-shifted with matching byte enables;
//            loads have the addressed byte/halfword extracted and sign- or
//            zero-extended so load_data can go straight to the register file.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            req_valid/req_ready    - request handshake (ready only in IDLE)
//            req_write, funct3      - store/load select and RV32I width code
//            addr, store_data       - byte address and rs2 value
//            done, err              - one-cycle completion / error pulses
//            load_data              - extended load result
//            mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
//            mem_rdata, mem_resp    - memory port
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_BUSY    = 2'd1;
    localparam logic [1:0]  c_RESP    = 2'd2;
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

    // Registered state and outputs
    logic [1:0]  r_state;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_load_data;
    logic [31:0] r_mem_address;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [15:0] r_count;

    // Next-state values
    logic [1:0]  w_state_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic [31:0] w_load_data_nxt;
    logic [31:0] w_mem_address_nxt;
    logic        w_mem_read_nxt;
    logic        w_mem_write_nxt;
    logic [31:0] w_mem_wdata_nxt;
    logic [3:0]  w_mem_be_nxt;
    logic [2:0]  w_funct3_nxt;
    logic [1:0]  w_addr_lo_nxt;
    logic [15:0] w_count_nxt;

    // Request decode
    logic        w_legal_f3;
    logic        w_aligned;
    logic        w_legal;
    logic [3:0]  w_req_be;
    logic [31:0] w_req_wdata;

    // Load extraction
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;
    logic [31:0] w_load_ext;
    logic [15:0] w_count_inc;

    // ------------------------------------------------------------------
    // Request legality, enables and lane-shifted write data
    // ------------------------------------------------------------------
    always_comb begin
        w_legal_f3 = 1'b0;
        if (req_write) begin
            w_legal_f3 = funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            w_legal_f3 = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end

        // funct3[1:0] encodes access size for both loads and stores
        case (funct3[1:0])
            2'b01:   w_aligned = ~addr[0];
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase

        w_legal = w_legal_f3 & w_aligned;

        w_req_be    = 4'b0000;
        w_req_wdata = 32'h0000_0000;
        if (req_write) begin
            case (funct3[1:0])
                2'b00:   w_req_be = 4'b0001 << addr[1:0];
                2'b01:   w_req_be = 4'b0011 << addr[1:0];
                default: w_req_be = 4'b1111;
            endcase
            w_req_wdata = store_data << {addr[1:0], 3'b000};
        end
    end

    // ------------------------------------------------------------------
    // Load lane extraction from the latched width code and byte offset
    // ------------------------------------------------------------------
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half   = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        // funct3[2] set means lbu/lhu
        w_signed = ~r_funct3[2];
        case (r_funct3[1:0])
            2'b00:   w_load_ext = {{24{w_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = {{16{w_signed & w_half[15]}}, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    assign w_count_inc = r_count + 16'd1;

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_done_nxt        = 1'b0;
        w_err_nxt         = 1'b0;
        w_load_data_nxt   = r_load_data;
        w_mem_address_nxt = r_mem_address;
        w_mem_read_nxt    = r_mem_read;
        w_mem_write_nxt   = r_mem_write;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_mem_be_nxt      = r_mem_be;
        w_funct3_nxt      = r_funct3;
        w_addr_lo_nxt     = r_addr_lo;
        w_count_nxt       = r_count;

        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    if (w_legal) begin
                        w_state_nxt       = c_BUSY;
                        w_funct3_nxt      = funct3;
                        w_addr_lo_nxt     = addr[1:0];
                        w_mem_address_nxt = {addr[31:2], 2'b00};
                        w_mem_wdata_nxt   = w_req_wdata;
                        w_mem_be_nxt      = w_req_be;
                        w_mem_read_nxt    = ~req_write;
                        w_mem_write_nxt   = req_write;
                        w_count_nxt       = 16'd0;
                    end else begin
                        // Illegal request: flag it and stay ready
                        w_err_nxt = 1'b1;
                    end
                end
            end

            c_BUSY: begin
                if (mem_resp) begin
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_state_nxt     = c_RESP;
                    // load_data only changes on a completed load
                    if (r_mem_read) begin
                        w_load_data_nxt = w_load_ext;
                    end
                end else begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == c_TIMEOUT) begin
                        w_mem_read_nxt  = 1'b0;
                        w_mem_write_nxt = 1'b0;
                        w_err_nxt       = 1'b1;
                        w_state_nxt     = c_IDLE;
                    end
                end
            end

            c_RESP: begin
                w_state_nxt = c_IDLE;
            end

            default: begin
                w_state_nxt     = c_IDLE;
                w_mem_read_nxt  = 1'b0;
                w_mem_write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_load_data   <= 32'h0000_0000;
            r_mem_address <= 32'h0000_0000;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_wdata   <= 32'h0000_0000;
            r_mem_be      <= 4'b0000;
            r_funct3      <= 3'b000;
            r_addr_lo     <= 2'b00;
            r_count       <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
            r_load_data   <= w_load_data_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_read    <= w_mem_read_nxt;
            r_mem_write   <= w_mem_write_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_mem_be      <= w_mem_be_nxt;
            r_funct3      <= w_funct3_nxt;
            r_addr_lo     <= w_addr_lo_nxt;
            r_count       <= w_count_nxt;
        end
    end

    // req_ready is a pure decode of the registered state
    assign req_ready       = (r_state == c_IDLE);
    assign done            = r_done;
    assign err             = r_err;
    assign load_data       = r_load_data;
    assign mem_address     = r_mem_address;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_wdata       = r_mem_wdata;
    assign mem_byte_enable = r_mem_be;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit, instantiated
//            with a 4-cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int checks;
    int errors;

    load_store_unit #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .funct3          (funct3),
        .addr            (addr),
        .store_data      (store_data),
        .done            (done),
        .err             (err),
        .load_data       (load_data),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then withdraw it
    task automatic issue(input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        req_valid  = 1'b1;
        req_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        tick();
        req_valid  = 1'b0;
    endtask

    // Respond in the first BUSY cycle
    task automatic respond(input logic [31:0] rd);
        mem_rdata = rd;
        mem_resp  = 1'b1;
        tick();
        mem_resp  = 1'b0;
    endtask

    // Full load with immediate response and result check
    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        chk1({tag, "_read"}, mem_read, 1'b1);
        respond(32'h80FF_1234);
        chk1({tag, "_done"}, done, 1'b1);
        chk32({tag, "_data"}, load_data, exp);
        tick();
        chk1({tag, "_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        mem_rdata  = 32'h0;
        mem_resp   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk1 ("rst_ready", req_ready, 1'b1);
        chk1 ("rst_done",  done, 1'b0);
        chk1 ("rst_err",   err, 1'b0);
        chk32("rst_ldata", load_data, 32'h0);
        chk1 ("rst_read",  mem_read, 1'b0);
        chk1 ("rst_write", mem_write, 1'b0);
        chk32("rst_addr",  mem_address, 32'h0);
        chk32("rst_wdata", mem_wdata, 32'h0);
        chk32("rst_be",    {28'h0, mem_byte_enable}, 32'h0);

        // lbu at 0x1003
        issue(1'b0, 3'b100, 32'h0000_1003, 32'h0);
        chk1 ("lbu_read",  mem_read, 1'b1);
        chk1 ("lbu_write", mem_write, 1'b0);
        chk32("lbu_addr",  mem_address, 32'h0000_1000);
        chk32("lbu_be",    {28'h0, mem_byte_enable}, 32'h0);
        chk1 ("lbu_busy_ready", req_ready, 1'b0);
        respond(32'h80FF_1234);
        chk1 ("lbu_read_drop", mem_read, 1'b0);
        chk1 ("lbu_done",  done, 1'b1);
        chk32("lbu_data",  load_data, 32'h0000_0080);
        chk1 ("lbu_resp_ready", req_ready, 1'b0);
        tick();
        chk1 ("lbu_done_pulse", done, 1'b0);
        chk1 ("lbu_ready", req_ready, 1'b1);
        chk32("lbu_hold",  load_data, 32'h0000_0080);

        // Signed/unsigned extraction variants
        do_load("lb",  3'b000, 32'h0000_1003, 32'hFFFF_FF80);
        do_load("lb0", 3'b000, 32'h0000_1000, 32'h0000_0034);
        do_load("lh",  3'b001, 32'h0000_1002, 32'hFFFF_80FF);
        do_load("lhu", 3'b101, 32'h0000_1002, 32'h0000_80FF);
        do_load("lh0", 3'b001, 32'h0000_1000, 32'h0000_1234);
        do_load("lw",  3'b010, 32'h0000_1000, 32'h80FF_1234);

        // sb at 0x2001 with one wait cycle
        issue(1'b1, 3'b000, 32'h0000_2001, 32'hAAAA_AA5C);
        chk1 ("sb_write", mem_write, 1'b1);
        chk1 ("sb_read",  mem_read, 1'b0);
        chk32("sb_addr",  mem_address, 32'h0000_2000);
        chk32("sb_wdata", mem_wdata, 32'hAAAA_5C00);
        chk32("sb_be",    {28'h0, mem_byte_enable}, 32'h0000_0002);
        tick();
        chk1 ("sb_write_hold", mem_write, 1'b1);
        chk1 ("sb_no_done", done, 1'b0);
        respond(32'h0);
        chk1 ("sb_write_drop", mem_write, 1'b0);
        chk1 ("sb_done", done, 1'b1);
        chk32("sb_ldata_kept", load_data, 32'h80FF_1234);
        tick();

        // sh at 0x2002
        issue(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
        chk32("sh_be",    {28'h0, mem_byte_enable}, 32'h0000_000C);
        chk32("sh_wdata", mem_wdata, 32'hABCD_0000);
        respond(32'h0);
        chk1 ("sh_done", done, 1'b1);
        tick();

        // Misaligned lw
        issue(1'b0, 3'b010, 32'h0000_3002, 32'h0);
        chk1("mis_err",   err, 1'b1);
        chk1("mis_read",  mem_read, 1'b0);
        chk1("mis_ready", req_ready, 1'b1);
        // Illegal load funct3 back-to-back
        issue(1'b0, 3'b011, 32'h0000_3000, 32'h0);
        chk1("ill_ld_err",  err, 1'b1);
        chk1("ill_ld_read", mem_read, 1'b0);
        // Illegal store funct3, then misaligned sh
        issue(1'b1, 3'b100, 32'h0000_3000, 32'h0);
        chk1("ill_st_err",   err, 1'b1);
        chk1("ill_st_write", mem_write, 1'b0);
        issue(1'b1, 3'b001, 32'h0000_3001, 32'h0);
        chk1("mis_sh_err", err, 1'b1);
        tick();
        chk1("err_pulse", err, 1'b0);
        chk1("err_idle_ready", req_ready, 1'b1);

        // Timeout: read high for exactly 4 cycles
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        chk1("to_read1", mem_read, 1'b1);
        tick();
        chk1("to_read2", mem_read, 1'b1);
        tick();
        chk1("to_read3", mem_read, 1'b1);
        tick();
        chk1("to_read4", mem_read, 1'b1);
        chk1("to_noerr", err, 1'b0);
        tick();
        chk1("to_read_drop", mem_read, 1'b0);
        chk1("to_err", err, 1'b1);
        chk1("to_ready", req_ready, 1'b1);
        tick();
        // Late response is ignored
        respond(32'h1111_1111);
        chk1 ("late_done", done, 1'b0);
        chk1 ("late_err",  err, 1'b0);
        chk32("late_data", load_data, 32'h80FF_1234);
        chk1 ("late_ready", req_ready, 1'b1);

        // Reset during BUSY
        issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        chk1("mid_read", mem_read, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1 ("mid_rst_read",  mem_read, 1'b0);
        chk1 ("mid_rst_ready", req_ready, 1'b1);
        chk1 ("mid_rst_done",  done, 1'b0);
        chk1 ("mid_rst_err",   err, 1'b0);
        chk32("mid_rst_addr",  mem_address, 32'h0);
        chk32("mid_rst_ldata", load_data, 32'h0);

        // sw completes normally after reset
        issue(1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF);
        chk1 ("sw_write", mem_write, 1'b1);
        chk32("sw_addr",  mem_address, 32'h0000_6000);
        chk32("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk32("sw_be",    {28'h0, mem_byte_enable}, 32'h0000_000F);
        respond(32'h0);
        chk1 ("sw_done",  done, 1'b1);
        chk1 ("sw_write_drop", mem_write, 1'b0);
        tick();
        chk1 ("sw_ready", req_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
